// File: rtl/mul_arbiter.sv
// Round-robin arbiter that lends one shared multi-cycle multiplier to two requesters.
// It has a watchdog on the multiplier's done signal. Every output is registered.
module mul_arbiter #(
    parameter int W   = 8,
    parameter int TMO = 300
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           rv0,
    output logic           rv1,
    output logic [2*W-1:0] res,
    output logic           err,
    output logic           busy,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    output logic           mul_start,
    output logic           mul_clr,
    input  logic           mul_done,
    input  logic [2*W-1:0] mul_p
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        RESP,
        ERR
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TMO - 1);

    state_t      state;
    logic        ptr;
    logic        owner;
    logic [15:0] cnt;

    // Winner selection: a lone request always wins, a tie goes to the pointer's side.
    logic         win;
    logic [W-1:0] win_a;
    logic [W-1:0] win_b;

    assign win   = (req0 && req1) ? ptr : req1;
    assign win_a = win ? a1 : a0;
    assign win_b = win ? b1 : b0;

    always_ff @(posedge clk) begin
        // NOTE: pulse outputs default low every cycle, and the states below raise them
        // for a single cycle. This block holds only state, so every assignment is non-blocking.
        gnt0      <= 1'b0;
        gnt1      <= 1'b0;
        rv0       <= 1'b0;
        rv1       <= 1'b0;
        res       <= '0;
        err       <= 1'b0;
        mul_start <= 1'b0;
        mul_clr   <= 1'b0;

        if (rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_clr <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= win;
                        mul_a     <= win_a;
                        mul_b     <= win_b;
                        gnt0      <= ~win;
                        gnt1      <= win;
                        mul_start <= (win_a != '0) && (win_b != '0);
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    // A zero operand means the product is known, so the multiplier is never started.
                    if (mul_a == '0 || mul_b == '0) begin
                        rv0     <= ~owner;
                        rv1     <= owner;
                        mul_clr <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (mul_done) begin
                        rv0     <= ~owner;
                        rv1     <= owner;
                        res     <= mul_p;
                        mul_clr <= 1'b1;
                        state   <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rv0     <= ~owner;
                        rv1     <= owner;
                        err     <= 1'b1;
                        mul_clr <= 1'b1;
                        state   <= ERR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RESP, ERR: begin
                    ptr   <= ~owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
